// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port synchronous RAM between the instruction-fetch port
// and the memory-stage (LDR/STR) port. Only one transaction is in flight at a
// time: IDLE grants, BUSY waits WAIT_CYCLES for the RAM, and RESP returns the
// result to the owner.
//
// Handshake: a requester raises *_req and holds it (with address/data stable)
// until it sees a one-cycle *_gnt. The grant is combinational in the request
// cycle and the request is latched on that edge. Exactly WAIT_CYCLES+1 cycles
// later the owner sees a one-cycle *_valid. Requests are looked at only in
// IDLE; one dropped before its grant is simply forgotten.
//
// Parameters
//   WAIT_CYCLES   RAM wait cycles after issue (1-15)
//   STARVE_LIMIT  data grants allowed back-to-back while fetch waits (1-15)
//
// Configuration macro
//   ARB_FAIRNESS_EN  when defined, a starvation counter forces a fetch grant
//                    after STARVE_LIMIT data grants; otherwise priority is
//                    strictly data-first.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   if_req/if_addr             fetch read request and word address
//   if_gnt/if_valid/if_rdata   fetch grant pulse, data-valid pulse, data
//   mem_req/mem_we/mem_addr/mem_wdata  data request (we=1 STR, 0 LDR)
//   mem_gnt/mem_valid/mem_rdata        data grant, completion pulse, load data
//   ram_addr/ram_wdata/ram_we/ram_rdata  RAM interface
//   sel_stall                  stall request to fetch/decode
//   dbg_state_o                current FSM state (debug observation)
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int unsigned WAIT_CYCLES  = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_valid,
  output logic [31:0] if_rdata,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        mem_gnt,
  output logic        mem_valid,
  output logic [31:0] mem_rdata,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  output logic        ram_we,
  input  logic [31:0] ram_rdata,
  output logic        sel_stall,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_e;

  localparam logic [3:0] WAIT_L = 4'(WAIT_CYCLES);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        owner_mem_q, owner_mem_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;

  logic        grant_if;
  logic        grant_mem;
  logic        fetch_first;

`ifdef ARB_FAIRNESS_EN
  localparam logic [3:0] STARVE_L = 4'(STARVE_LIMIT);
  logic [3:0] starve_q, starve_d;

  assign fetch_first = (starve_q == STARVE_L);

  // Counts data grants taken while fetch was waiting; saturates at the limit.
  always_comb begin
    starve_d = starve_q;
    if (grant_if) begin
      starve_d = '0;
    end else if (grant_mem && if_req && (starve_q < STARVE_L)) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) starve_q <= '0;
    else        starve_q <= starve_d;
  end
`else
  assign fetch_first = 1'b0;
`endif

  // Arbitration. Gated by rst_n so that no grant escapes while reset is held.
  always_comb begin
    grant_mem = 1'b0;
    grant_if  = 1'b0;
    if (rst_n && (state_q == S_IDLE)) begin
      if (mem_req && !(fetch_first && if_req)) grant_mem = 1'b1;
      else if (if_req)                         grant_if  = 1'b1;
    end
  end

  // State register and latched transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      owner_mem_q <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_mem_q <= owner_mem_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_mem_d = owner_mem_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (grant_mem || grant_if) begin
          state_d     = S_BUSY;
          cnt_d       = WAIT_L;
          owner_mem_d = grant_mem;
          we_d        = grant_mem && mem_we;
          addr_d      = grant_mem ? mem_addr : if_addr;
          wdata_d     = grant_mem ? mem_wdata : 32'd0;
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - 4'd1;
        // Last wait cycle: capture the RAM output (stores complete with 0).
        if (cnt_q == 4'd1) begin
          state_d = S_RESP;
          rdata_d = we_q ? 32'd0 : ram_rdata;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs.
  always_comb begin
    if_gnt    = grant_if;
    mem_gnt   = grant_mem;
    if_valid  = 1'b0;
    mem_valid = 1'b0;
    if_rdata  = '0;
    mem_rdata = '0;
    ram_addr  = '0;
    ram_wdata = '0;
    ram_we    = 1'b0;
    if (state_q != S_IDLE) begin
      ram_addr  = addr_q;
      ram_wdata = wdata_q;
    end
    // The counter still holds its load value only in the first BUSY cycle.
    if ((state_q == S_BUSY) && (cnt_q == WAIT_L) && we_q) ram_we = 1'b1;
    if (state_q == S_RESP) begin
      if (owner_mem_q) begin
        mem_valid = 1'b1;
        mem_rdata = rdata_q;
      end else begin
        if_valid = 1'b1;
        if_rdata = rdata_q;
      end
    end
    // Fetch is treated as owning the port from its grant cycle onward, so the
    // stall stays high continuously from request until read data returns.
    sel_stall = rst_n &&
                ((if_req && !grant_if) ||
                 ((grant_if || ((state_q != S_IDLE) && !owner_mem_q)) && !if_valid));
  end

  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

`ifdef ARB_FAIRNESS_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif
  localparam int LIMIT = 4;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // index 0: WAIT_CYCLES=1, index 1: WAIT_CYCLES=3
  logic        if_req    [2];
  logic [31:0] if_addr   [2];
  logic        if_gnt    [2];
  logic        if_valid  [2];
  logic [31:0] if_rdata  [2];
  logic        mem_req   [2];
  logic        mem_we    [2];
  logic [31:0] mem_addr  [2];
  logic [31:0] mem_wdata [2];
  logic        mem_gnt   [2];
  logic        mem_valid [2];
  logic [31:0] mem_rdata [2];
  logic [31:0] ram_addr  [2];
  logic [31:0] ram_wdata [2];
  logic        ram_we    [2];
  logic [31:0] ram_rdata [2];
  logic        sel_stall [2];
  logic [1:0]  dbg_state [2];

  mem_port_arbiter #(.WAIT_CYCLES(1), .STARVE_LIMIT(LIMIT)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req[0]), .if_addr(if_addr[0]), .if_gnt(if_gnt[0]),
    .if_valid(if_valid[0]), .if_rdata(if_rdata[0]),
    .mem_req(mem_req[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_gnt(mem_gnt[0]), .mem_valid(mem_valid[0]),
    .mem_rdata(mem_rdata[0]), .ram_addr(ram_addr[0]), .ram_wdata(ram_wdata[0]),
    .ram_we(ram_we[0]), .ram_rdata(ram_rdata[0]), .sel_stall(sel_stall[0]),
    .dbg_state_o(dbg_state[0])
  );

  mem_port_arbiter #(.WAIT_CYCLES(3), .STARVE_LIMIT(LIMIT)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req[1]), .if_addr(if_addr[1]), .if_gnt(if_gnt[1]),
    .if_valid(if_valid[1]), .if_rdata(if_rdata[1]),
    .mem_req(mem_req[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_gnt(mem_gnt[1]), .mem_valid(mem_valid[1]),
    .mem_rdata(mem_rdata[1]), .ram_addr(ram_addr[1]), .ram_wdata(ram_wdata[1]),
    .ram_we(ram_we[1]), .ram_rdata(ram_rdata[1]), .sel_stall(sel_stall[1]),
    .dbg_state_o(dbg_state[1])
  );

  // ---------------- RAM (combinational read for the capture edge) ----------------
  function automatic logic [31:0] init_val(input logic [31:0] a);
    if (a == 32'h40) return 32'hE3A01005;
    return 32'hA500_0000 | a;
  endfunction

  logic [31:0] ram_mem [2][4096];
  bit          ram_wr  [2][4096];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (ram_we[i]) begin
        ram_mem[i][ram_addr[i][11:0]] <= ram_wdata[i];
        ram_wr[i][ram_addr[i][11:0]]  <= 1'b1;
      end
    end
  end

  assign ram_rdata[0] = ram_wr[0][ram_addr[0][11:0]] ? ram_mem[0][ram_addr[0][11:0]]
                                                     : init_val(ram_addr[0]);
  assign ram_rdata[1] = ram_wr[1][ram_addr[1][11:0]] ? ram_mem[1][ram_addr[1][11:0]]
                                                     : init_val(ram_addr[1]);

  // ---------------- scoreboard counters ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // since = cycles elapsed since the grant edge (-1 when nothing is in flight)
  int          since     [2] = '{-1, -1};
  int          starve    [2] = '{0, 0};
  bit          m_own_mem [2];
  bit          m_we      [2];
  logic [31:0] m_addr    [2];
  logic [31:0] m_wdata   [2];
  logic [31:0] m_mem     [2][4096];
  bit          m_wr      [2][4096];
  bit          g_if      [2];
  bit          g_mem     [2];

  function automatic int wc(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic logic [31:0] model_rd(input int i, input logic [31:0] a);
    return m_wr[i][a[11:0]] ? m_mem[i][a[11:0]] : init_val(a);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        since[i]     <= -1;
        starve[i]    <= 0;
        m_own_mem[i] <= 1'b0;
        m_we[i]      <= 1'b0;
        m_addr[i]    <= '0;
        m_wdata[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (since[i] < 0) begin
          if (g_mem[i]) begin
            since[i]     <= 1;
            m_own_mem[i] <= 1'b1;
            m_we[i]      <= mem_we[i];
            m_addr[i]    <= mem_addr[i];
            m_wdata[i]   <= mem_wdata[i];
            if (if_req[i] && starve[i] < LIMIT) starve[i] <= starve[i] + 1;
          end else if (g_if[i]) begin
            since[i]     <= 1;
            m_own_mem[i] <= 1'b0;
            m_we[i]      <= 1'b0;
            m_addr[i]    <= if_addr[i];
            m_wdata[i]   <= '0;
            starve[i]    <= 0;
          end
        end else if (since[i] == wc(i) + 1) begin
          since[i] <= -1;
        end else begin
          since[i] <= since[i] + 1;
        end
        if (since[i] == 1 && m_we[i]) begin
          m_mem[i][m_addr[i][11:0]] <= m_wdata[i];
          m_wr[i][m_addr[i][11:0]]  <= 1'b1;
        end
      end
    end
  end

  // Compare process: every cycle, both instances.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      bit e_ig, e_mg, e_iv, e_mv, e_we, e_st, own_if;
      logic [31:0] e_ir, e_mr, e_ra, e_rw;
      e_ig = 0; e_mg = 0; e_iv = 0; e_mv = 0; e_we = 0; e_st = 0; own_if = 0;
      e_ir = '0; e_mr = '0; e_ra = '0; e_rw = '0;
      if (rst_n) begin
        if (since[i] < 0) begin
          if (mem_req[i] && !(FAIR && starve[i] >= LIMIT && if_req[i])) e_mg = 1;
          else if (if_req[i])                                           e_ig = 1;
        end else begin
          e_ra = m_addr[i];
          e_rw = m_wdata[i];
          e_we = (since[i] == 1) && m_we[i];
          if (since[i] == wc(i) + 1) begin
            if (m_own_mem[i]) begin
              e_mv = 1;
              e_mr = m_we[i] ? 32'd0 : model_rd(i, m_addr[i]);
            end else begin
              e_iv = 1;
              e_ir = model_rd(i, m_addr[i]);
            end
          end
        end
        own_if = e_ig || (since[i] > 0 && !m_own_mem[i]);
        e_st   = (if_req[i] && !e_ig) || (own_if && !e_iv);
      end
      g_if[i]  <= e_ig;
      g_mem[i] <= e_mg;
      chk($sformatf("dut%0d_if_gnt", i),    32'(if_gnt[i]),    32'(e_ig));
      chk($sformatf("dut%0d_mem_gnt", i),   32'(mem_gnt[i]),   32'(e_mg));
      chk($sformatf("dut%0d_if_valid", i),  32'(if_valid[i]),  32'(e_iv));
      chk($sformatf("dut%0d_mem_valid", i), 32'(mem_valid[i]), 32'(e_mv));
      chk($sformatf("dut%0d_if_rdata", i),  if_rdata[i],       e_ir);
      chk($sformatf("dut%0d_mem_rdata", i), mem_rdata[i],      e_mr);
      chk($sformatf("dut%0d_ram_addr", i),  ram_addr[i],       e_ra);
      chk($sformatf("dut%0d_ram_wdata", i), ram_wdata[i],      e_rw);
      chk($sformatf("dut%0d_ram_we", i),    32'(ram_we[i]),    32'(e_we));
      chk($sformatf("dut%0d_sel_stall", i), 32'(sel_stall[i]), 32'(e_st));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < 2; i++) begin
      if_req[i] = 0; if_addr[i] = '0;
      mem_req[i] = 0; mem_we[i] = 0; mem_addr[i] = '0; mem_wdata[i] = '0;
    end
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    logic [1:0] idle_code;
    int nm, ni, first;
    logic [5:0] exp_g, exp_v;
    clear_inputs();
    rst_n = 0;
    // Requests during reset must not leak through.
    if_req[0] = 1; mem_req[0] = 1;
    repeat (2) tick();
    @(negedge clk);
    chk("rst_if_gnt",    32'(if_gnt[0]),    32'd0);
    chk("rst_mem_gnt",   32'(mem_gnt[0]),   32'd0);
    chk("rst_sel_stall", 32'(sel_stall[0]), 32'd0);
    chk("rst_ram_we",    32'(ram_we[0]),    32'd0);
    idle_code = dbg_state[0];
    tick();
    rst_n = 1; if_req[0] = 0; mem_req[0] = 0;
    tick();

    // A: fetch read, WAIT_CYCLES=1; a data request appears in BUSY and is withdrawn.
    if_req[0] = 1; if_addr[0] = 32'h40;
    @(negedge clk);
    chk("A_T_if_gnt",    32'(if_gnt[0]),    32'd1);
    chk("A_T_stall",     32'(sel_stall[0]), 32'd1);
    tick();
    if_req[0] = 0; mem_req[0] = 1; mem_addr[0] = 32'h500;
    @(negedge clk);
    chk("A_T1_stall",    32'(sel_stall[0]), 32'd1);
    chk("A_T1_ram_addr", ram_addr[0],       32'h40);
    chk("A_T1_busy",     32'(dbg_state[0] != idle_code), 32'd1);
    tick();
    mem_req[0] = 0;
    @(negedge clk);
    chk("A_T2_if_valid", 32'(if_valid[0]),  32'd1);
    chk("A_T2_if_rdata", if_rdata[0],       32'hE3A01005);
    chk("A_T2_stall",    32'(sel_stall[0]), 32'd0);
    tick();
    @(negedge clk);
    chk("A_T3_no_gnt",   32'(mem_gnt[0]),   32'd0);
    chk("A_T3_idle",     32'(dbg_state[0] == idle_code), 32'd1);
    tick();

    // B: store then load back.
    mem_req[0] = 1; mem_we[0] = 1; mem_addr[0] = 32'h100; mem_wdata[0] = 32'hDEADBEEF;
    @(negedge clk);
    chk("B_T_mem_gnt",   32'(mem_gnt[0]),   32'd1);
    chk("B_T_ram_we",    32'(ram_we[0]),    32'd0);
    tick();
    mem_req[0] = 0;
    @(negedge clk);
    chk("B_T1_ram_we",   32'(ram_we[0]),    32'd1);
    chk("B_T1_ram_addr", ram_addr[0],       32'h100);
    chk("B_T1_ram_wdata", ram_wdata[0],     32'hDEADBEEF);
    tick();
    @(negedge clk);
    chk("B_T2_mem_valid", 32'(mem_valid[0]), 32'd1);
    chk("B_T2_mem_rdata", mem_rdata[0],      32'd0);
    chk("B_T2_ram_we",    32'(ram_we[0]),    32'd0);
    tick();
    mem_req[0] = 1; mem_we[0] = 0; mem_addr[0] = 32'h100;
    tick();
    mem_req[0] = 0;
    tick();
    @(negedge clk);
    chk("B_rd_valid",    32'(mem_valid[0]), 32'd1);
    chk("B_rd_data",     mem_rdata[0],      32'hDEADBEEF);
    tick();

    // C: simultaneous requests, data wins, fetch granted at T+3.
    if_req[0] = 1; if_addr[0] = 32'h44;
    mem_req[0] = 1; mem_we[0] = 0; mem_addr[0] = 32'h200;
    @(negedge clk);
    chk("C_T_mem_gnt",   32'(mem_gnt[0]),   32'd1);
    chk("C_T_if_gnt",    32'(if_gnt[0]),    32'd0);
    chk("C_T_stall",     32'(sel_stall[0]), 32'd1);
    tick();
    mem_req[0] = 0;
    tick();
    @(negedge clk);
    chk("C_T2_mem_rdata", mem_rdata[0],     32'hA5000200);
    chk("C_T2_stall",    32'(sel_stall[0]), 32'd1);
    tick();
    @(negedge clk);
    chk("C_T3_if_gnt",   32'(if_gnt[0]),    32'd1);
    tick();
    if_req[0] = 0;
    @(negedge clk);
    chk("C_T4_stall",    32'(sel_stall[0]), 32'd1);
    tick();
    @(negedge clk);
    chk("C_T5_if_valid", 32'(if_valid[0]),  32'd1);
    chk("C_T5_if_rdata", if_rdata[0],       32'hA5000044);
    chk("C_T5_stall",    32'(sel_stall[0]), 32'd0);
    tick();

    // D: both requests held continuously.
    if_req[0] = 1; if_addr[0] = 32'h80;
    mem_req[0] = 1; mem_we[0] = 0; mem_addr[0] = 32'h600;
    nm = 0; ni = 0; first = -1;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (mem_gnt[0]) nm++;
      if (if_gnt[0]) begin
        ni++;
        if (first < 0) first = nm;
      end
      tick();
    end
    if_req[0] = 0; mem_req[0] = 0;
`ifdef ARB_FAIRNESS_EN
    chk("D_mem_grants", 32'(nm), 32'd4);
    chk("D_if_grants",  32'(ni), 32'd1);
    chk("D_if_after",   32'(first), 32'd4);
`else
    chk("D_mem_grants", 32'(nm), 32'd5);
    chk("D_if_grants",  32'(ni), 32'd0);
`endif
    repeat (3) tick();

    // E: reset in BUSY of a store.
    mem_req[0] = 1; mem_we[0] = 1; mem_addr[0] = 32'h300; mem_wdata[0] = 32'h12345678;
    tick();
    mem_req[0] = 0; mem_we[0] = 0;
    @(negedge clk);
    chk("E_T1_ram_we",   32'(ram_we[0]),    32'd1);
    #2;
    rst_n = 0; if_req[0] = 1; if_addr[0] = 32'h48;
    #1;
    chk("E_rst_ram_we",  32'(ram_we[0]),    32'd0);
    chk("E_rst_if_gnt",  32'(if_gnt[0]),    32'd0);
    chk("E_rst_stall",   32'(sel_stall[0]), 32'd0);
    tick();
    rst_n = 1;
    @(negedge clk);
    chk("E_rel_if_gnt",  32'(if_gnt[0]),    32'd1);
    chk("E_rel_mem_valid", 32'(mem_valid[0]), 32'd0);
    tick();
    if_req[0] = 0;
    @(negedge clk);
    chk("E_T1_mem_valid", 32'(mem_valid[0]), 32'd0);
    tick();
    @(negedge clk);
    chk("E_T2_if_valid", 32'(if_valid[0]),  32'd1);
    chk("E_T2_if_rdata", if_rdata[0],       32'hA5000048);
    tick();
    mem_req[0] = 1; mem_we[0] = 0; mem_addr[0] = 32'h300;
    tick();
    mem_req[0] = 0;
    tick();
    @(negedge clk);
    chk("E_abort_rdata", mem_rdata[0],      32'hA5000300);
    tick();

    // F: WAIT_CYCLES=3 instance, fetch held so the second grant shows the gap.
    if_req[1] = 1; if_addr[1] = 32'h40;
    exp_g = 6'b100001;
    exp_v = 6'b010000;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("F_T%0d_if_gnt", k),   32'(if_gnt[1]),   32'(exp_g[k]));
      chk($sformatf("F_T%0d_if_valid", k), 32'(if_valid[1]), 32'(exp_v[k]));
      if (k == 4) chk("F_T4_if_rdata", if_rdata[1], 32'hE3A01005);
      tick();
    end
    if_req[1] = 0;
    repeat (6) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not complete, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: WAIT_CYCLES, default 1, RAM read/write wait cycles after issue (legal 1-15).
REQ-002 Parameter: STARVE_LIMIT, default 4, consecutive data grants allowed while fetch waits (legal 1-15).
REQ-003 Port: clk  in  1  single clock; all state updates on the rising edge.
REQ-004 Port: rst_n  in  1  asynchronous, active-low reset.
REQ-005 Port: if_req  in  1  fetch read request; held until if_gnt.
REQ-006 Port: if_addr  in  32  fetch word address.
REQ-007 Port: if_gnt / if_valid  out  1 each  fetch grant pulse / read-data-valid pulse.
REQ-008 Port: if_rdata  out  32  fetch read data; meaningful only while if_valid is high.
REQ-009 Port: mem_req, mem_we  in  1 each  memory-stage request; 1 = STR, 0 = LDR; held until mem_gnt.
REQ-010 Port: mem_addr, mem_wdata  in  32 each  memory-stage address and store data.
REQ-011 Port: mem_gnt / mem_valid  out  1 each  data grant pulse / completion pulse (LDR data or STR ack).
REQ-012 Port: mem_rdata  out  32  load data; 0 on STR completion.
REQ-013 Port: ram_addr, ram_wdata  out  32 each; ram_we  out  1; ram_rdata  in  32  single-port synchronous RAM.
REQ-014 Port: sel_stall  out  1  pipeline stall request to the fetch/decode stages.

Function
REQ-015 FSM states IDLE, BUSY, RESP; IDLE is the only state that grants.
REQ-016 In IDLE, grant is combinational in the request cycle T: exactly one of if_gnt/mem_gnt is high for one cycle; the owner and the address, we, and wdata are latched at edge T.
REQ-017 Priority is data-stage first (mem_req over if_req) except as in REQ-024.
REQ-018 From T+1 ram_addr and ram_wdata are driven from latched values until the return to IDLE; ram_we is high only in cycle T+1 and only for a data write.
REQ-019 BUSY lasts WAIT_CYCLES cycles (a 4-bit down-counter); ram_rdata is captured on the final BUSY edge.
REQ-020 RESP lasts one cycle (T+1+WAIT_CYCLES): the owner's valid pulses with captured data; other outputs stay 0; next state IDLE.
REQ-021 The earliest next grant is cycle T+2+WAIT_CYCLES; requests arriving in BUSY/RESP wait.
REQ-022 sel_stall = (if_req AND NOT if_gnt) OR (fetch owns an in-flight transaction AND NOT if_valid); it is combinational.
REQ-023 Idle outputs: ram_we=0; if_rdata/mem_rdata=0 when not valid; no grant while both requests are low.
REQ-024 Starvation counter (4-bit): increments on each mem_gnt while if_req is high, saturating at STARVE_LIMIT; clears on if_gnt. When it equals STARVE_LIMIT with both requests high, fetch is granted.
REQ-025 A request withdrawn before grant is ignored without error; requests are sampled only in IDLE.

Reset
REQ-026 rst_n low immediately forces: state IDLE, all outputs 0 (including ram_we), counters 0, latched owner/address/data 0.
REQ-027 Reset mid-transaction abandons it: no valid pulse follows; the first grant is possible in the first cycle after rst_n rises.

Configuration
REQ-028 Macro ARB_FAIRNESS_EN: when defined, REQ-024 is implemented; when undefined, the starvation counter is absent and priority is strict data-first with no fetch guarantee.

Verification
REQ-029 Reset, then if_req with if_addr=0x40 and ram holding 0xE3A01005 -> if_gnt at T, if_valid with if_rdata=0xE3A01005 at T+2 (WAIT_CYCLES=1), sel_stall high T..T+1 only.
REQ-030 mem_req/mem_we=1, addr 0x100, wdata 0xDEADBEEF -> ram_we=1 only at T+1 with ram_addr=0x100; mem_valid at T+2 with mem_rdata=0.
REQ-031 if_req and mem_req both high in the same cycle -> mem_gnt first; if_gnt at T+3; sel_stall high from T until if_valid.
REQ-032 With ARB_FAIRNESS_EN and STARVE_LIMIT=4, mem_req held continuously with if_req -> 4 mem grants, then if_gnt; without the macro -> no if_gnt while mem_req is high.
REQ-033 rst_n pulsed low in BUSY of a write -> ram_we low immediately, no mem_valid; a new if_req grants in the first cycle after release.
REQ-034 WAIT_CYCLES=3 with a read -> valid at T+4, next grant no earlier than T+5.
